// File: rtl/tcb_lib_memory_pkg.sv
// Shared types and limits for the TCB memory subordinate and its response delay line.
package tcb_lib_memory_pkg;

  localparam int unsigned TCB_DLY_MAX  = 4;
  localparam int unsigned TCB_WAIT_MAX = 15;
  localparam int unsigned TCB_DBW      = 32;
  localparam int unsigned TCB_CNTW     = 4;

  typedef struct packed {
    logic [TCB_DBW-1:0] rdt;
    logic               err;
  } tcb_rsp_t;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } mem_state_e;

  // Preload for the wait counter; the last wait cycle is the one with cnt==0.
  function automatic logic [TCB_CNTW-1:0] wait_init(input int unsigned wait_cycles);
    if (wait_cycles == 0) begin
      return '0;
    end
    return TCB_CNTW'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/tcb_lib_memory_pipe.sv
// DLY-stage response delay line carrying {valid, rdt, err}; idle stages present zeros.
module tcb_lib_memory_pipe #(
  parameter int unsigned DLY = 1,
  parameter int unsigned DBW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  input  logic [DBW-1:0] in_rdt,
  input  logic           in_err,
  output logic           out_vld,
  output logic [DBW-1:0] out_rdt,
  output logic           out_err
);

  logic [DLY-1:0] vld_q;
  logic [DLY-1:0] err_q;
  logic [DBW-1:0] rdt_q [DLY];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      for (int k = 1; k < int'(DLY); k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  // Payload needs no reset: the valid bits gate what reaches the outputs.
  always_ff @(posedge clk) begin
    rdt_q[0] <= in_vld ? in_rdt : '0;
    err_q[0] <= in_vld & in_err;
    for (int k = 1; k < int'(DLY); k++) begin
      rdt_q[k] <= rdt_q[k-1];
      err_q[k] <= err_q[k-1];
    end
  end

  always_comb begin
    out_vld = vld_q[DLY-1];
    out_rdt = vld_q[DLY-1] ? rdt_q[DLY-1] : '0;
    out_err = vld_q[DLY-1] & err_q[DLY-1];
  end

endmodule

// File: rtl/tcb_lib_memory.sv
// Synthesizable TCB subordinate: byte-enabled RAM with optional wait states and a fixed
// DLY-cycle response latency.
module tcb_lib_memory
  import tcb_lib_memory_pkg::*;
#(
  parameter int unsigned ABW  = 32,
  parameter int unsigned DBW  = 32,
  parameter int unsigned SIZ  = 1024,
  parameter int unsigned WAIT = 0,
  parameter int unsigned DLY  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tcb_vld,
  input  logic             tcb_wen,
  input  logic [ABW-1:0]   tcb_adr,
  input  logic [DBW/8-1:0] tcb_ben,
  input  logic [DBW-1:0]   tcb_wdt,
  output logic             tcb_rdy,
  output logic [DBW-1:0]   tcb_rdt,
  output logic             tcb_err
);

  localparam int unsigned BEW   = DBW / 8;
  localparam int unsigned OFF   = $clog2(BEW);
  localparam int unsigned IW    = ABW - OFF;
  localparam int unsigned DEPTH = SIZ / BEW;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TCB_CNTW-1:0] WaitInit = wait_init(WAIT);

  if (DLY < 1 || DLY > TCB_DLY_MAX) begin : g_bad_dly
    $error("tcb_lib_memory: DLY=%0d outside 1..%0d", DLY, TCB_DLY_MAX);
  end
  if (WAIT > TCB_WAIT_MAX) begin : g_bad_wait
    $error("tcb_lib_memory: WAIT=%0d exceeds %0d", WAIT, TCB_WAIT_MAX);
  end
  if (SIZ % BEW != 0 || DEPTH == 0) begin : g_bad_siz
    $error("tcb_lib_memory: SIZ=%0d must be a nonzero multiple of %0d", SIZ, BEW);
  end

  // Aligned bus: the byte offset within a word carries no information.
  if (OFF > 0) begin : g_unused_off
    logic unused_adr_off;
    assign unused_adr_off = ^tcb_adr[OFF-1:0];
  end

  // ------------------------------------------------------------------
  // Wait-state FSM
  // ------------------------------------------------------------------
  mem_state_e          state_q, state_d;
  logic [TCB_CNTW-1:0] cnt_q, cnt_d;
  logic                trn;

  assign trn = tcb_vld & tcb_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (WAIT != 0 && tcb_vld) begin
          state_d = StWait;
          cnt_d   = WaitInit;
        end
      end
      StWait: begin
        // A dropped request abandons the wait without a transfer.
        if (trn || !tcb_vld) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    tcb_rdy = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:  tcb_rdy = (WAIT == 0);
        StWait:  tcb_rdy = (cnt_q == '0);
        default: tcb_rdy = 1'b0;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Address decode and memory array
  // ------------------------------------------------------------------
  logic [IW-1:0] idx;
  logic [AW-1:0] widx;
  logic          in_range;

  assign idx      = tcb_adr[ABW-1:OFF];
  assign widx     = idx[AW-1:0];
  // One extra bit so a DEPTH equal to 2**IW still compares correctly.
  assign in_range = ({1'b0, idx} < (IW+1)'(DEPTH));

  logic [DBW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && trn && tcb_wen && in_range) begin
      for (int i = 0; i < int'(BEW); i++) begin
        if (tcb_ben[i]) begin
          mem[widx][8*i +: 8] <= tcb_wdt[8*i +: 8];
        end
      end
    end
  end

  logic [DBW-1:0] rsp_rdt;
  logic           rsp_err;

  // Writes answer with zero data; out-of-range answers with err and zero data.
  always_comb begin
    rsp_rdt = '0;
    rsp_err = 1'b0;
    if (!in_range) begin
      rsp_err = 1'b1;
    end else if (!tcb_wen) begin
      for (int i = 0; i < int'(BEW); i++) begin
        if (tcb_ben[i]) begin
          rsp_rdt[8*i +: 8] = mem[widx][8*i +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Response delay line
  // ------------------------------------------------------------------
  logic unused_rsp_vld;

  tcb_lib_memory_pipe #(
    .DLY (DLY),
    .DBW (DBW)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (trn),
    .in_rdt  (rsp_rdt),
    .in_err  (rsp_err),
    .out_vld (unused_rsp_vld),
    .out_rdt (tcb_rdt),
    .out_err (tcb_err)
  );

endmodule
